// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// State encoding and timer sizing live here.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    PLL_RESET,
    WAIT_LOCK,
    STABLE,
    RUN
  } state_e;

  // Width of the shared down-counter: enough to hold the largest reload.
  function automatic int tmr_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous status bit.
// Clears to 0 on reset; output is the last flop in the chain.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;
  logic [STAGES-1:0] ff_d;

  // Shift the raw input one stage deeper each cycle.
  always_comb begin
    ff_d = {ff_q[STAGES-2:0], d};
  end

  // Chain registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= '0;
    else        ff_q <= ff_d;
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives PLL reset, qualifies lock, and gates the pixel-domain reset.
// One shared down-counter times every state.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             lock_ok,
  output logic             timeout_err,
  output logic [CNT_W-1:0] lock_loss_count
);

  localparam int TW = tmr_width(PLL_RST_CYCLES, LOCK_TIMEOUT,
                                STABLE_CYCLES);

  localparam logic [TW-1:0] RST_LD = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LD  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STB_LD = TW'(STABLE_CYCLES - 1);

  logic lock_s;

  state_e           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             lock_ok_q, lock_ok_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (refclk),
    .rst_n(rst),
    .d    (locked),
    .q    (lock_s)
  );

  // State and output registers.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q       <= PLL_RESET;
      tmr_q         <= RST_LD;
      pll_rst_q     <= 1'b1;
      sys_rst_n_q   <= 1'b0;
      lock_ok_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      pll_rst_q     <= pll_rst_d;
      sys_rst_n_q   <= sys_rst_n_d;
      lock_ok_q     <= lock_ok_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next-state decision; lock takes priority over timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PLL_RESET: if (tmr_q == '0) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s)             state_d = STABLE;
        else if (tmr_q == '0)   state_d = PLL_RESET;
      end
      STABLE: begin
        if (!lock_s)            state_d = WAIT_LOCK;
        else if (tmr_q == '0)   state_d = RUN;
      end
      RUN: if (!lock_s) state_d = PLL_RESET;
    endcase
  end

  // Timer reloads on every state change, else counts down to zero.
  always_comb begin
    tmr_d = tmr_q;
    if (state_d != state_q) begin
      unique case (state_d)
        PLL_RESET: tmr_d = RST_LD;
        WAIT_LOCK: tmr_d = TO_LD;
        STABLE:    tmr_d = STB_LD;
        RUN:       tmr_d = '0;
      endcase
    end else if (tmr_q != '0) begin
      tmr_d = tmr_q - 1'b1;
    end
  end

  // Outputs registered from the next state; sticky error and loss count.
  always_comb begin
    pll_rst_d     = (state_d == PLL_RESET);
    sys_rst_n_d   = (state_d == RUN);
    lock_ok_d     = (state_d == RUN);
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;
    if (state_q == WAIT_LOCK && state_d == PLL_RESET)
      timeout_err_d = 1'b1;
    if (state_q == RUN && state_d == PLL_RESET && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  assign pll_rst         = pll_rst_q;
  assign sys_rst_n       = sys_rst_n_q;
  assign lock_ok         = lock_ok_q;
  assign timeout_err     = timeout_err_q;
  assign lock_loss_count = cnt_q;

endmodule
